pool1_relu: RTL and testbench
=============================

POOL1_RELU -- requirements
Module: pool1_relu

Interface
REQ-001 SHALL have parameter CONV_BIT, default 12, meaning the signed width of each conv-channel sample.
REQ-002 SHALL have parameter IN_WIDTH, default 24, meaning conv feature-map columns per row.
REQ-003 SHALL have parameter IN_HEIGHT, default 24, meaning conv feature-map rows per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, high when conv_in_1..3 carry one feature-map pixel.
REQ-007 SHALL have ports conv_in_1, conv_in_2, conv_in_3, input, CONV_BIT each, signed two's-complement channel samples.
REQ-008 SHALL have ports max_value_1, max_value_2, max_value_3, output, CONV_BIT each, pooled and rectified results.
REQ-009 SHALL have port valid_out_relu, output, 1, one-cycle strobe marking max_value_1..3 as valid.

Function
REQ-010 SHALL consume pixels in raster order (row-major, column 0 first), one pixel per cycle in which valid_in=1.
REQ-011 SHALL ignore conv_in_* and hold all internal state in cycles where valid_in=0 (gaps allowed anywhere).
REQ-012 SHALL keep a column counter 0..IN_WIDTH-1 and a row counter 0..IN_HEIGHT-1, advanced only on accepted pixels.
REQ-013 SHALL, on an even column, register the sample per channel as the left operand of the horizontal pair.
REQ-014 SHALL, on an odd column of an even row, write the signed max of the pair into line-buffer entry col>>1 (IN_WIDTH/2 entries per channel).
REQ-015 SHALL, on an odd column of an odd row, compute the signed max of the pair and buffer entry col>>1, then apply ReLU (negative -> 0).
REQ-016 SHALL register the REQ-015 result onto max_value_* and assert valid_out_relu for exactly one cycle, latency 1 clock after the 4th pixel of the 2x2 window is accepted.
REQ-017 SHALL hold max_value_* at their last values while valid_out_relu=0.
REQ-018 SHALL emit (IN_WIDTH/2)*(IN_HEIGHT/2) = 144 strobes per frame, in raster order of the pooled map.
REQ-019 SHALL compare with signed arithmetic; equal operands yield that value; 0x800 (-2048) is a legal input and rectifies to 0.
REQ-020 SHALL wrap column to 0 and increment row after column IN_WIDTH-1; after the last pixel of row IN_HEIGHT-1 both counters wrap to 0 and the next accepted pixel starts a new frame with no dead cycle.
REQ-021 SHALL treat all three channels identically and in lockstep; a single strobe covers all three outputs.

Reset
REQ-022 SHALL, while rst=1, force counters, pair registers, line buffers, max_value_* and valid_out_relu to 0 asynchronously.
REQ-023 SHALL, on rst asserted mid-frame, discard the partial frame; the first pixel accepted after release is treated as row 0, column 0.
REQ-024 SHALL produce no strobe in the cycle reset deasserts.

Structure
REQ-025 SHALL take CONV_BIT, IN_WIDTH, IN_HEIGHT and the derived POOL_WIDTH=IN_WIDTH/2 from the shared CNN parameter package.
REQ-026 SHALL implement the per-channel datapath (pair register, line buffer, compare, ReLU, output register) as sub-module pool1_chan, instantiated three times; counters and valid logic live once in pool1_relu.
REQ-027 SHALL infer line buffers as registers (12 x CONV_BIT per channel), no RAM macro.

Verification
REQ-028 Window (row0: 5, -3; row1: 7, 2) on ch1 -> max_value_1=7 one cycle after 4th pixel, valid_out_relu high 1 cycle.
REQ-029 All-negative window (-1,-20,-2048,-5) on ch2 -> max_value_2=0 with strobe.
REQ-030 Full 24x24 frame, pixel value = row*24+col on all channels -> exactly 144 strobes, k-th output = (2r+1)*24+(2c+1) for pooled (r,c).
REQ-031 Same frame with random valid_in gaps (~40% low) -> identical output sequence to REQ-030, no extra strobes.
REQ-032 rst pulsed after 300 pixels, then fresh frame -> outputs 0 during reset, then 144 correct strobes for the new frame only.
REQ-033 Two back-to-back frames, no idle cycle -> 288 strobes; frame-2 first output depends only on frame-2 pixels.

Source files
------------

// File: rtl/pool1_relu_pkg.sv
// Shared CNN layer-1 constants and the per-pixel operation code that steers
// every pooling channel through its 2x2 max-pool window.
package pool1_relu_pkg;

  localparam int CNN_CONV_BIT   = 12;
  localparam int CNN_IN_WIDTH   = 24;
  localparam int CNN_IN_HEIGHT  = 24;
  localparam int CNN_POOL_WIDTH = CNN_IN_WIDTH / 2;

  typedef enum logic [1:0] {
    OP_IDLE,   // no pixel accepted this cycle
    OP_LEFT,   // even column: capture left operand of the horizontal pair
    OP_STORE,  // odd column, even row: park the pair max in the line buffer
    OP_EMIT    // odd column, odd row: close the 2x2 window and emit
  } pool_op_e;

  // Where an accepted pixel sits in its 2x2 window decides what the channels do.
  function automatic pool_op_e decode_op(input logic accept,
                                         input logic col_odd,
                                         input logic row_odd);
    if (!accept)  return OP_IDLE;
    if (!col_odd) return OP_LEFT;
    return row_odd ? OP_EMIT : OP_STORE;
  endfunction

endpackage

// File: rtl/pool1_chan.sv
// One channel of the 2x2 max-pool + ReLU: pair register, half-row line
// buffer, signed compare tree and output register.
module pool1_chan
  import pool1_relu_pkg::*;
#(
  parameter int CONV_BIT   = CNN_CONV_BIT,
  parameter int POOL_WIDTH = CNN_POOL_WIDTH,
  parameter int IDX_W      = (POOL_WIDTH > 1) ? $clog2(POOL_WIDTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  pool_op_e                   op_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic signed [CONV_BIT-1:0] sample_i,
  output logic signed [CONV_BIT-1:0] max_value_o
);

  typedef logic signed [CONV_BIT-1:0] sample_t;

  sample_t left_q, left_d;
  sample_t max_q, max_d;
  sample_t line_q [POOL_WIDTH];
  sample_t line_d [POOL_WIDTH];
  sample_t pair_max, win_max;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; every output gets a default first so no latch is inferred.
    pair_max = smax(left_q, sample_i);
    win_max  = smax(pair_max, line_q[idx_i]);
    left_d   = left_q;
    max_d    = max_q;
    line_d   = line_q;
    case (op_i)
      OP_LEFT:  left_d        = sample_i;
      OP_STORE: line_d[idx_i] = pair_max;
      OP_EMIT:  max_d         = win_max[CONV_BIT-1] ? '0 : win_max;
      default:  ;
    endcase
  end

  // NOTE: the line buffer is a register array, so it can and does take the
  // reset; a RAM-inferred buffer would have to be left unreset instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= '0;
      max_q  <= '0;
      line_q <= '{default: '0};
    end else begin
      left_q <= left_d;
      max_q  <= max_d;
      line_q <= line_d;
    end
  end

  assign max_value_o = max_q;

endmodule

// File: rtl/pool1_relu.sv
// 2x2 stride-2 max-pool followed by ReLU over a raster-order, three-channel
// conv feature map; one shared raster counter steers three channel datapaths.
module pool1_relu
  import pool1_relu_pkg::*;
#(
  parameter int CONV_BIT  = CNN_CONV_BIT,
  parameter int IN_WIDTH  = CNN_IN_WIDTH,
  parameter int IN_HEIGHT = CNN_IN_HEIGHT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] conv_in_1,
  input  logic signed [CONV_BIT-1:0] conv_in_2,
  input  logic signed [CONV_BIT-1:0] conv_in_3,
  output logic signed [CONV_BIT-1:0] max_value_1,
  output logic signed [CONV_BIT-1:0] max_value_2,
  output logic signed [CONV_BIT-1:0] max_value_3,
  output logic                       valid_out_relu
);

  localparam int POOL_WIDTH = IN_WIDTH / 2;
  localparam int COL_W      = $clog2(IN_WIDTH);
  localparam int ROW_W      = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int IDX_W      = COL_W - 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q, valid_d;
  pool_op_e         op;

  always_comb begin
    op      = decode_op(valid_in, col_q[0], row_q[0]);
    valid_d = (op == OP_EMIT);
    col_d   = col_q;
    row_d   = row_q;
    if (valid_in) begin
      if (col_q == COL_W'(IN_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IN_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out_relu = valid_q;

  // Line-buffer slot is the pooled column, i.e. the input column without its LSB.
  pool1_chan #(.CONV_BIT(CONV_BIT), .POOL_WIDTH(POOL_WIDTH), .IDX_W(IDX_W)) u_chan_1 (
    .clk         (clk),
    .rst         (rst),
    .op_i        (op),
    .idx_i       (col_q[COL_W-1:1]),
    .sample_i    (conv_in_1),
    .max_value_o (max_value_1)
  );

  pool1_chan #(.CONV_BIT(CONV_BIT), .POOL_WIDTH(POOL_WIDTH), .IDX_W(IDX_W)) u_chan_2 (
    .clk         (clk),
    .rst         (rst),
    .op_i        (op),
    .idx_i       (col_q[COL_W-1:1]),
    .sample_i    (conv_in_2),
    .max_value_o (max_value_2)
  );

  pool1_chan #(.CONV_BIT(CONV_BIT), .POOL_WIDTH(POOL_WIDTH), .IDX_W(IDX_W)) u_chan_3 (
    .clk         (clk),
    .rst         (rst),
    .op_i        (op),
    .idx_i       (col_q[COL_W-1:1]),
    .sample_i    (conv_in_3),
    .max_value_o (max_value_3)
  );

endmodule

// File: tb/tb_pool1_relu.sv
// Bench for pool1_relu: frame-level max-pool/ReLU model checked every cycle,
// plus literal expectations for hand-computed windows and frame endpoints.
module tb_pool1_relu;

  localparam int CB    = 12;
  localparam int W     = 24;
  localparam int H     = 24;
  localparam int FRAME = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic signed [CB-1:0] in1 = '0, in2 = '0, in3 = '0;
  logic signed [CB-1:0] max_value_1, max_value_2, max_value_3;
  logic valid_out_relu;

  always #5 clk = ~clk;

  pool1_relu dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .conv_in_1      (in1),
    .conv_in_2      (in2),
    .conv_in_3      (in3),
    .max_value_1    (max_value_1),
    .max_value_2    (max_value_2),
    .max_value_3    (max_value_3),
    .valid_out_relu (valid_out_relu)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Model: remember the whole frame, emit max-of-4 (rectified) whenever a
  // pixel lands at an odd row and odd column of the feature map.
  logic signed [CB-1:0] pix [3][H][W];
  int                   m_n = 0;
  logic                 exp_strobe = 1'b0;
  logic signed [CB-1:0] exp_m [3];

  always @(posedge clk) begin : model
    int r, c, best;
    logic signed [CB-1:0] cur [3];
    if (rst) begin
      m_n        <= 0;
      exp_strobe <= 1'b0;
      for (int k = 0; k < 3; k++) exp_m[k] <= '0;
    end else begin
      exp_strobe <= 1'b0;
      if (valid_in) begin
        r   = m_n / W;
        c   = m_n % W;
        cur = '{in1, in2, in3};
        for (int k = 0; k < 3; k++) pix[k][r][c] <= cur[k];
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          for (int k = 0; k < 3; k++) begin
            best = imax(imax(pix[k][r-1][c-1], pix[k][r-1][c]),
                        imax(pix[k][r][c-1], cur[k]));
            exp_m[k] <= (best < 0) ? '0 : CB'(best);
          end
          exp_strobe <= 1'b1;
        end
        m_n <= (m_n + 1) % FRAME;
      end
    end
  end

  int seg_q [$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", valid_out_relu, 0);
      check("rst_max1", max_value_1, 0);
      check("rst_max2", max_value_2, 0);
      check("rst_max3", max_value_3, 0);
    end else begin
      check("strobe", valid_out_relu, exp_strobe);
      check("max1", max_value_1, exp_m[0]);
      check("max2", max_value_2, exp_m[1]);
      check("max3", max_value_3, exp_m[2]);
      if (valid_out_relu === 1'b1) seg_q.push_back(int'(max_value_1));
    end
  end

  task automatic drive(input logic v, input int a, input int b, input int c);
    @(posedge clk);
    #1;
    valid_in = v;
    in1 = CB'(a);
    in2 = CB'(b);
    in3 = CB'(c);
  endtask

  // Last pixel is accepted on the next edge; its strobe is visible at the following negedge.
  task automatic finish_stream();
    drive(1'b0, $urandom, $urandom, $urandom);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic feed_frame(input int base, input int gap_pct, input bit rnd);
    int v;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (gap_pct > 0 && $urandom_range(99) < gap_pct)
          drive(1'b0, $urandom, $urandom, $urandom);
        if (rnd) begin
          drive(1'b1, $urandom, $urandom, $urandom);
        end else begin
          v = base + r * W + c;
          drive(1'b1, v, v, v);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic seg_check(input string name, input int cnt, input int first, input int last);
    check({name, "_count"}, seg_q.size(), cnt);
    if (seg_q.size() > 0) begin
      check({name, "_first"}, seg_q[0], first);
      check({name, "_last"}, seg_q[$], last);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-computed 2x2 window at the top-left corner
    drive(1'b1, 5, -1, 100);
    drive(1'b1, -3, -20, -100);
    for (int c = 2; c < W; c++) drive(1'b1, 0, 0, 0);
    drive(1'b1, 7, -2048, -7);
    drive(1'b1, 2, -5, 50);
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    check("win_strobe", valid_out_relu, 1);
    check("win_ch1", max_value_1, 7);
    check("win_ch2_relu", max_value_2, 0);
    check("win_ch3", max_value_3, 100);
    @(negedge clk);
    check("win_strobe_once", valid_out_relu, 0);
    check("win_hold_ch1", max_value_1, 7);
    pulse_reset();

    // Ramp frame, no gaps
    seg_q.delete();
    feed_frame(0, 0, 1'b0);
    finish_stream();
    seg_check("ramp", 144, 25, 575);

    // Same frame with ~40% idle cycles
    seg_q.delete();
    feed_frame(0, 40, 1'b0);
    finish_stream();
    seg_check("gaps", 144, 25, 575);

    // Reset in the middle of a frame, then a fresh frame
    for (int n = 0; n < 300; n++) drive(1'b1, n, n, n);
    pulse_reset();
    seg_q.delete();
    feed_frame(0, 0, 1'b0);
    finish_stream();
    seg_check("after_rst", 144, 25, 575);

    // Two frames back to back; frame 2 offset by 1000
    seg_q.delete();
    feed_frame(0, 0, 1'b0);
    feed_frame(1000, 0, 1'b0);
    finish_stream();
    seg_check("b2b", 288, 25, 1575);
    if (seg_q.size() > 144) begin
      check("b2b_f1_last", seg_q[143], 575);
      check("b2b_f2_first", seg_q[144], 1025);
    end

    // Random full-range data with gaps, values checked by the model
    seg_q.delete();
    feed_frame(0, 30, 1'b1);
    finish_stream();
    check("rand_count", seg_q.size(), 144);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
